// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour bit indices and derived-total helpers.
// Combinational only, no handshake.
package vga_pkg;
  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  // Raw (active-high) timing flags carried through the alignment delay line
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_t;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 48;
  localparam int H_BP_DEF     = 88;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 13;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 32;

  localparam int RED   = 2;
  localparam int GREEN = 1;
  localparam int BLUE  = 0;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage, WIDTH-bit shift register (DEPTH=0 is a wire); latency DEPTH clocks.
// No backpressure: shifts every clock, stages reset to RST_VAL.
module sync_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             VGA_CLOCK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V counters and sync/blank decode; pins lag PIXEL_H/V by PIPE_DELAY+1 clocks.
// Free-running, no backpressure; RGB forced to 0 while blanked.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic        VGA_CLOCK,
  input  logic        RESET_N,
  input  logic [2:0]  PIXEL_IN,
  output logic [10:0] PIXEL_H,
  output logic [10:0] PIXEL_V,
  output logic        ACTIVE,
  output logic        FRAME_START,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG   = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG   = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t  h_cnt;
  cnt_t  v_cnt;
  sync_t raw;
  sync_t dly;

  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  // Decoded regions; vs only moves when h_cnt wraps because v_cnt does
  always_comb begin
    raw        = '0;
    raw.active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    raw.hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    raw.vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   ($bits(sync_t)),
    .RST_VAL ('0)
  ) u_align (
    .VGA_CLOCK (VGA_CLOCK),
    .RESET_N   (RESET_N),
    .din       (raw),
    .dout      (dly)
  );

  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_R  <= 1'b0;
      VGA_G  <= 1'b0;
      VGA_B  <= 1'b0;
      VGA_HS <= ~HS_POL;
      VGA_VS <= ~VS_POL;
    end else begin
      VGA_R  <= dly.active & PIXEL_IN[RED];
      VGA_G  <= dly.active & PIXEL_IN[GREEN];
      VGA_B  <= dly.active & PIXEL_IN[BLUE];
      VGA_HS <= dly.hs ~^ HS_POL;
      VGA_VS <= dly.vs ~^ VS_POL;
    end
  end

  assign PIXEL_H     = h_cnt;
  assign PIXEL_V     = v_cnt;
  assign ACTIVE      = raw.active;
  assign FRAME_START = (h_cnt == '0) && (v_cnt == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks a default-timing instance and a shrunken-timing instance (PIPE_DELAY=0, positive syncs)
// against an arithmetic raster model, plus hand-derived spot vectors and pulse-width counts.
module tb_vga_timing_gen;
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        act;
    logic        fs;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
  } obs_t;

  typedef struct {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    bit hpol; bit vpol; int pd;
  } tcfg_t;

  typedef struct {
    int          k;
    logic [10:0] h;
    logic [10:0] v;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] pin_d = 3'b111;
  logic [2:0] pin_s = 3'b000;

  logic [10:0] d_h, d_v, s_h, s_v;
  logic d_act, d_fs, d_r, d_g, d_b, d_hs, d_vs;
  logic s_act, s_fs, s_r, s_g, s_b, s_hs, s_vs;

  int nvec = 0;
  int nbad = 0;
  int kd = 0;
  int ks = 0;
  int mode = 0;          // 0: constant white, 1: aligned pixel source, 2: random
  bit win_en = 1'b0;
  int hs_low_cnt = 0, rgb_on_cnt = 0, fs_cnt = 0, sm_hs_cnt = 0, sm_vs_cnt = 0;
  tcfg_t cd, cs;
  vec_t tbl[14];

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .VGA_CLOCK(clk), .RESET_N(rst_n), .PIXEL_IN(pin_d),
    .PIXEL_H(d_h), .PIXEL_V(d_v), .ACTIVE(d_act), .FRAME_START(d_fs),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(0)
  ) u_sm (
    .VGA_CLOCK(clk), .RESET_N(rst_n), .PIXEL_IN(pin_s),
    .PIXEL_H(s_h), .PIXEL_V(s_v), .ACTIVE(s_act), .FRAME_START(s_fs),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs)
  );

  // Expected outputs k edges after reset release; pprev is the colour offered during state k-1
  function automatic obs_t model(input tcfg_t c, input int k, input logic [2:0] pprev);
    int ht, vt, h, v, j, jh, jv;
    obs_t o;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    h  = k % ht;
    v  = (k / ht) % vt;
    j  = k - 1 - c.pd;
    o.h   = 11'(h);
    o.v   = 11'(v);
    o.act = (h < c.ha) && (v < c.va);
    o.fs  = (h == 0) && (v == 0);
    if (j < 0) begin
      o.rgb = 3'b000;
      o.hs  = ~c.hpol;
      o.vs  = ~c.vpol;
    end else begin
      jh = j % ht;
      jv = (j / ht) % vt;
      o.rgb = ((jh < c.ha) && (jv < c.va)) ? pprev : 3'b000;
      o.hs  = (jh >= c.ha + c.hf && jh < c.ha + c.hf + c.hsw) ? c.hpol : ~c.hpol;
      o.vs  = (jv >= c.va + c.vf && jv < c.va + c.vf + c.vsw) ? c.vpol : ~c.vpol;
    end
    return o;
  endfunction

  function automatic obs_t obs_def();
    return {d_h, d_v, d_act, d_fs, d_r, d_g, d_b, d_hs, d_vs};
  endfunction

  function automatic obs_t obs_sm();
    return {s_h, s_v, s_act, s_fs, s_r, s_g, s_b, s_hs, s_vs};
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      if (nbad <= 40) $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  function automatic logic [2:0] next_pin_d(input int k);
    int j;
    case (mode)
      0: return 3'b111;
      1: begin
        j = k - 2;
        if (j < 0) return 3'b000;
        return {1'(((j % 976) % 2)), 2'b00};
      end
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  // One clock: advance, compare both instances against the model, then offer next colours
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      kd++;
      ks++;
    end
    @(negedge clk);
    check("def_cycle", kd, 32'(obs_def()), 32'(model(cd, kd, pin_d)));
    check("sm_cycle", ks, 32'(obs_sm()), 32'(model(cs, ks, pin_s)));
    if (win_en) begin
      if (kd >= 3 && kd < 979) begin
        if (!d_hs) hs_low_cnt++;
        if (d_r && d_g && d_b) rgb_on_cnt++;
      end
      if (kd < 1952 && d_fs) fs_cnt++;
      if (ks >= 1 && ks < 528) begin
        if (s_hs) sm_hs_cnt++;
        if (s_vs) sm_vs_cnt++;
      end
    end
    pin_d = next_pin_d(kd);
    pin_s = 3'($urandom_range(0, 7));
  endtask

  initial begin
    cd = '{800, 40, 48, 88, 480, 13, 3, 32, 1'b0, 1'b0, 2};
    cs = '{16, 4, 6, 5, 10, 2, 3, 2, 1'b1, 1'b1, 0};

    // Default instance, PIXEL_IN held white; hs active-low, pins lag coordinates by 3
    tbl[0]  = '{0,    11'd0,   11'd0, 3'b000, 1'b1, 1'b1};
    tbl[1]  = '{2,    11'd2,   11'd0, 3'b000, 1'b1, 1'b1};
    tbl[2]  = '{3,    11'd3,   11'd0, 3'b111, 1'b1, 1'b1};
    tbl[3]  = '{802,  11'd802, 11'd0, 3'b111, 1'b1, 1'b1};
    tbl[4]  = '{803,  11'd803, 11'd0, 3'b000, 1'b1, 1'b1};
    tbl[5]  = '{842,  11'd842, 11'd0, 3'b000, 1'b1, 1'b1};
    tbl[6]  = '{843,  11'd843, 11'd0, 3'b000, 1'b0, 1'b1};
    tbl[7]  = '{890,  11'd890, 11'd0, 3'b000, 1'b0, 1'b1};
    tbl[8]  = '{891,  11'd891, 11'd0, 3'b000, 1'b1, 1'b1};
    tbl[9]  = '{975,  11'd975, 11'd0, 3'b000, 1'b1, 1'b1};
    tbl[10] = '{976,  11'd0,   11'd1, 3'b000, 1'b1, 1'b1};
    tbl[11] = '{979,  11'd3,   11'd1, 3'b111, 1'b1, 1'b1};
    tbl[12] = '{1818, 11'd842, 11'd1, 3'b000, 1'b1, 1'b1};
    tbl[13] = '{1819, 11'd843, 11'd1, 3'b000, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_def", 0, 32'(obs_def()), 32'(model(cd, 0, pin_d)));
    check("reset_sm", 0, 32'(obs_sm()), 32'(model(cs, 0, pin_s)));
    rst_n = 1'b1;
    kd = 0;
    ks = 0;
    win_en = 1'b1;
    if (d_fs) fs_cnt++;

    for (int i = 0; i < 14; i++) begin
      for (int g = 0; g < 2000 && kd < tbl[i].k; g++) step();
      check("table", tbl[i].k, 32'({d_h, d_v, d_r, d_g, d_b, d_hs, d_vs}),
            32'({tbl[i].h, tbl[i].v, tbl[i].rgb, tbl[i].hs, tbl[i].vs}));
    end
    while (kd < 2000) step();
    win_en = 1'b0;
    check("hs_low_width", kd, 32'(hs_low_cnt), 32'd48);
    check("rgb_visible_line0", kd, 32'(rgb_on_cnt), 32'd800);
    check("frame_start_count", kd, 32'(fs_cnt), 32'd1);
    check("sm_hs_per_frame", ks, 32'(sm_hs_cnt), 32'(17 * 6));
    check("sm_vs_per_frame", ks, 32'(sm_vs_cnt), 32'(3 * 31));

    mode = 2;
    repeat (500) step();

    // Mid-line reset at h=400: everything returns to reset values immediately
    for (int g = 0; g < 976 && (kd % 976) != 400; g++) step();
    check("pre_reset_h", kd, 32'(d_h), 32'd400);
    rst_n = 1'b0;
    kd = 0;
    ks = 0;
    #1;
    check("async_reset_def", 0, 32'(obs_def()), 32'(model(cd, 0, pin_d)));
    check("async_reset_sm", 0, 32'(obs_sm()), 32'(model(cs, 0, pin_s)));
    mode = 1;
    repeat (5) step();
    rst_n = 1'b1;

    // Aligned pixel source: first visible pixel is even (red off), next is odd
    repeat (3) step();
    check("first_pixel_r", kd, 32'(d_r), 32'd0);
    step();
    check("second_pixel_r", kd, 32'(d_r), 32'd1);
    repeat (2000) step();

    mode = 2;
    repeat (1000) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
